// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader
package loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_ERROR
    } loader_state_t;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int LEN_BITS = 16;
    function automatic logic in_frame(loader_state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    endfunction
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle watchdog between accepted bytes of a frame
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
        if (!reset || !enable || kick) cnt <= '0;
        else if (!expired) cnt <= cnt + 1'b1;
    assign expired = enable && cnt == LIMIT;
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader writing program RAM and gating core reset
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 12,
    parameter int         DATA_WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [LEN_BITS:0] MAX_LEN = (LEN_BITS+1)'(1) << ADDR_WIDTH;
    loader_state_t state, next_state;
    logic [LEN_BITS-1:0] len, word_cnt, len_full;
    logic [7:0] word_hi, checksum;
    logic [15:0] word_full;
    logic expired, sync_hit, len_bad, last_word;
    logic start, ld_len_hi, ld_len_lo, ld_hi, wr, sum_en, ok, fail;
    assign rx_ready  = 1'b1;
    assign sync_hit  = rx_data == SYNC_BYTE;
    assign len_full  = {len[15:8], rx_data};
    assign len_bad   = {1'b0, len_full} > MAX_LEN;
    assign last_word = word_cnt == len - 16'd1;
    assign word_full = {word_hi, rx_data};
    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (in_frame(state)),
        .kick   (rx_valid),
        .expired(expired)
    );
    always_ff @(posedge clk)
        state <= !reset ? S_IDLE : next_state;
    // A watchdog expiry wins over a byte arriving in the same cycle
    always_comb begin
        next_state = state;
        if (expired) next_state = S_ERROR;
        else if (rx_valid)
            case (state)
                S_IDLE, S_ERROR: next_state = sync_hit ? S_LEN_HI : state;
                S_LEN_HI:        next_state = S_LEN_LO;
                S_LEN_LO:        next_state = len_full == '0 ? S_CHECK : len_bad ? S_ERROR : S_DATA_HI;
                S_DATA_HI:       next_state = S_DATA_LO;
                S_DATA_LO:       next_state = last_word ? S_CHECK : S_DATA_HI;
                S_CHECK:         next_state = rx_data == checksum ? S_IDLE : S_ERROR;
                default:         next_state = S_IDLE;
            endcase
    end
    always_comb begin
        start     = rx_valid && !expired && (state == S_IDLE || state == S_ERROR) && sync_hit;
        ld_len_hi = rx_valid && !expired && state == S_LEN_HI;
        ld_len_lo = rx_valid && !expired && state == S_LEN_LO;
        ld_hi     = rx_valid && !expired && state == S_DATA_HI;
        wr        = rx_valid && !expired && state == S_DATA_LO;
        sum_en    = ld_len_hi || ld_len_lo || ld_hi || wr;
        ok        = state == S_CHECK && next_state == S_IDLE;
        fail      = state != S_ERROR && next_state == S_ERROR;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            checksum  <= '0;
            word_cnt  <= '0;
            len       <= '0;
            word_hi   <= '0;
        end else begin
            done    <= ok;
            prog_we <= wr;
            if (prog_we) prog_addr <= prog_addr + 1'b1;
            if (start) begin
                checksum  <= '0;
                error     <= 1'b0;
                prog_addr <= '0;
                word_cnt  <= '0;
                core_hold <= 1'b1;
                busy      <= 1'b1;
            end
            if (sum_en) checksum <= checksum ^ rx_data;
            if (ld_len_hi) len[15:8] <= rx_data;
            if (ld_len_lo) len[7:0] <= rx_data;
            if (ld_hi) word_hi <= rx_data;
            // prog_data is its own buffer, so the next byte can be taken during the write
            if (wr) begin
                prog_data <= word_full[DATA_WIDTH-1:0];
                word_cnt  <= word_cnt + 1'b1;
            end
            if (ok) begin
                core_hold <= 1'b0;
                busy      <= 1'b0;
            end
            if (fail) begin
                error <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frame vectors with hand-computed expectations
module tb_program_loader;
    logic        clk = 1'b0, reset = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, prog_we, core_hold, busy, done, error;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;
    logic [7:0]  frame[$];
    logic [11:0] wa[$];
    logic [15:0] wd[$];
    logic [7:0]  sum;
    int done_cnt = 0, vectors = 0, miscompares = 0, base = 0;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (prog_we) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_data);
        end
        if (done) done_cnt++;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task send_frame;
        foreach (frame[i]) begin
            rx_data  = frame[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        check("rst_ready", rx_ready, 1);
        check("rst_we", prog_we, 0);
        check("rst_addr", prog_addr, 0);
        check("rst_data", prog_data, 0);
        check("rst_hold", core_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b1;
        idle(1);

        base = wa.size();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        send_frame();
        check("t1_hold_mid", core_hold, 1);
        check("t1_busy_mid", busy, 1);
        frame = '{8'h0A};
        send_frame();
        check("t1_done", done, 1);
        check("t1_hold_rel", core_hold, 0);
        check("t1_busy_end", busy, 0);
        check("t1_error", error, 0);
        idle(1);
        check("t1_done_pulse", done, 0);
        check("t1_nwr", wa.size() - base, 2);
        check("t1_a0", wa[base], 0);
        check("t1_d0", wd[base], 16'h1234);
        check("t1_a1", wa[base+1], 1);
        check("t1_d1", wd[base+1], 16'h5678);
        check("t1_done_cnt", done_cnt, 1);

        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
        send_frame();
        check("t2_done", done, 0);
        check("t2_error", error, 1);
        check("t2_hold", core_hold, 1);
        check("t2_busy", busy, 0);
        idle(2);
        check("t2_done_cnt", done_cnt, 1);
        frame = '{8'hA5};
        send_frame();
        check("t2_err_clr", error, 0);
        check("t2_busy_re", busy, 1);
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        send_frame();
        check("t2_done_re", done, 1);
        check("t2_hold_rel", core_hold, 0);
        idle(1);
        check("t2_done_cnt2", done_cnt, 2);

        base = wa.size();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame();
        check("t3_done", done, 1);
        check("t3_addr", prog_addr, 0);
        check("t3_hold", core_hold, 0);
        idle(1);
        check("t3_nwr", wa.size() - base, 0);

        frame = '{8'hA5, 8'h10, 8'h01};
        send_frame();
        check("t4_error", error, 1);
        check("t4_hold", core_hold, 1);
        check("t4_busy", busy, 0);
        idle(4);
        check("t4_nwr", wa.size() - base, 0);

        frame = '{8'hA5, 8'h00};
        send_frame();
        idle(4);
        check("t5_error", error, 1);
        check("t5_busy", busy, 0);
        check("t5_hold", core_hold, 1);
        frame = '{8'h00, 8'h01};
        send_frame();
        idle(2);
        check("t5_ignored_err", error, 1);
        check("t5_ignored_busy", busy, 0);
        check("t5_nwr", wa.size() - base, 0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame();
        check("t5_recover_done", done, 1);
        check("t5_recover_err", error, 0);
        idle(1);

        base = wa.size();
        frame = '{8'hA5, 8'h10, 8'h00};
        sum = 8'h10;
        for (int i = 0; i < 4096; i++) begin
            frame.push_back(8'(i >> 8));
            frame.push_back(8'(i));
            sum ^= 8'(i >> 8) ^ 8'(i);
        end
        frame.push_back(sum);
        send_frame();
        check("t6_done", done, 1);
        idle(1);
        check("t6_nwr", wa.size() - base, 4096);
        check("t6_a123", wa[base+291], 12'h123);
        check("t6_d123", wd[base+291], 16'h0123);
        check("t6_alast", wa[base+4095], 12'hFFF);
        check("t6_dlast", wd[base+4095], 16'h0FFF);
        check("t6_wrap", prog_addr, 0);

        base = wa.size();
        frame = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_frame();
        check("t7_busy_mid", busy, 1);
        reset    = 1'b0;
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("t7_we", prog_we, 0);
        check("t7_hold", core_hold, 0);
        check("t7_busy", busy, 0);
        check("t7_error", error, 0);
        check("t7_addr", prog_addr, 0);
        check("t7_done", done, 0);
        reset = 1'b1;
        idle(2);
        check("t7_nwr", wa.size() - base, 0);
        check("t7_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
